// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: fixed-latency multiply, radix-2 restoring divide.
// Optional macro MULDIV_EARLY_OUT_EN finishes trivial divides (zero divisor, |a|<|b|) in one cycle.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic             done_q, done_d;

  logic             accept, is_mul, is_div, early;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rs, diff;
  logic signed [2*WIDTH-1:0] ma, mb, prod;

  assign accept = (state_q == IDLE) && req_valid;
  assign is_mul = (req_op == OP_MULT) || (req_op == OP_MULTU);
  assign is_div = (req_op == OP_DIV)  || (req_op == OP_DIVU);
  assign abs_a  = (req_op == OP_DIV && req_a[WIDTH-1]) ? -req_a : req_a;
  assign abs_b  = (req_op == OP_DIV && req_b[WIDTH-1]) ? -req_b : req_b;
`ifdef MULDIV_EARLY_OUT_EN
  assign early  = (req_b == '0) || (abs_a < abs_b);
`else
  assign early  = 1'b0;
`endif

  // Operands extended to full product width so the low 2*WIDTH bits are exact for both signedness.
  assign ma   = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
  assign mb   = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
  assign prod = ma * mb;
  assign rs   = {rem_q, quo_q[WIDTH-1]};
  assign diff = rs - {1'b0, b_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && is_mul)      state_d = MUL;
            else if (accept && is_div) state_d = early ? FIX : DIV;
      MUL:  if (cancel || cnt_q == '0)      state_d = IDLE;
      DIV:  if (cancel)                     state_d = IDLE;
            else if (cnt_q == CW'(1))       state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    sgn_d  = sgn_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        if (is_mul) begin
          a_d   = req_a;
          b_d   = req_b;
          sgn_d = (req_op == OP_MULT);
          cnt_d = CW'(MUL_STAGES - 1);
        end else if (is_div) begin
          a_d    = req_a;
          b_d    = abs_b;
          sgn_d  = (req_op == OP_DIV);
          qneg_d = (req_op == OP_DIV) && (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
          rneg_d = (req_op == OP_DIV) && req_a[WIDTH-1];
          dz_d   = (req_b == '0);
          cnt_d  = CW'(WIDTH);
          // Early-out skips the iterations: quotient 0, remainder is the whole dividend.
          quo_d  = early ? '0 : abs_a;
          rem_d  = early ? abs_a : '0;
        end else if (req_op == OP_MTHI) begin
          hi_d = req_a;
        end else if (req_op == OP_MTLO) begin
          lo_d = req_a;
        end
      end
      MUL: if (!cancel) begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = prod;
          done_d       = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DIV: if (!cancel) begin
        rem_d = diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q - CW'(1);
      end
      FIX: if (!cancel) begin
        // Divide by zero reports the raw dividend in HI regardless of sign handling.
        if (dz_q) begin
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = qneg_q ? -quo_q : quo_q;
          hi_d = rneg_q ? -rem_q : rem_q;
        end
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    done      = done_q;
    hi        = hi_q;
    lo        = lo_q;
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32, MUL_STAGES=2): directed vectors, decoupled done monitor.
module tb_muldiv_unit;
  localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2,
                         OP_DIVU = 3'd3, OP_MTHI = 3'd4, OP_MTLO = 3'd5;
  localparam int ML = 2;
  localparam int DL = 33;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EL = 1;
`else
  localparam int EL = 33;
`endif

  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, cancel = 1'b0, busy, done;
  logic [2:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0, hi, lo;

  typedef struct { logic [31:0] hi; logic [31:0] lo; int cyc; } exp_t;
  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0, n_err = 0;

  muldiv_unit #(.WIDTH(32), .MUL_STAGES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result, in the expected cycle.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_hi", hi, e.hi);
        check("done_lo", lo, e.lo);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, b, input bit push,
                       input logic [31:0] ehi, elo, input int lat, input bit can);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; cancel = can;
    @(posedge clk); #1;
    req_valid = 1'b0; cancel = 1'b0; req_a = $urandom; req_b = $urandom;
    if (push) sb.push_back('{ehi, elo, cyc + lat});
  endtask

  task automatic run(input string nm, input logic [2:0] op, input logic [31:0] a, b,
                     input logic [31:0] ehi, elo, input int lat, input bit can = 1'b0);
    int n;
    issue(op, a, b, 1'b1, ehi, elo, lat, can);
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy || n > 100) break;
      n++;
    end
    check({nm, "_busy_cycles"}, n, lat);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 1);
    check("rst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    run("mult_neg",  OP_MULT,  32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, ML);
    run("multu",     OP_MULTU, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, ML);
    run("div_m7_2",  OP_DIV,   32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, DL);
    run("divu_dz",   OP_DIVU,  32'd5,        32'h0, 32'h00000005, 32'hFFFFFFFF, EL);
    run("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,   32'h80000000, DL);
    run("div_p_n",   OP_DIV,   32'd100,      32'hFFFFFFF9, 32'h2,   32'hFFFFFFF2, DL);
    run("div_n_p",   OP_DIV,   32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, DL);
    run("div_s_dz",  OP_DIV,   32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF, EL);
    run("mult_m3_5", OP_MULT,  32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, ML);
    run("multu_min", OP_MULTU, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, ML);
    // Cancel asserted in IDLE alongside the request is ignored.
    run("multu_can", OP_MULTU, 32'd3, 32'd4, 32'h0, 32'hC, ML, 1'b1);

    // Divide cancelled mid-flight; an MTLO attempted while busy must be dropped.
    issue(OP_DIV, 32'd100, 32'd7, 1'b0, 0, 0, 0, 1'b0);
    @(negedge clk); req_valid = 1'b1; req_op = OP_MTLO; req_a = 32'hDEAD;
    @(negedge clk); req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    check("cancel_busy_before", busy, 1);
    @(posedge clk); #1 cancel = 1'b0;
    check("cancel_busy_after", busy, 0);
    check("cancel_hi", hi, 32'h0);
    check("cancel_lo", lo, 32'hC);
    repeat (40) @(negedge clk);
    check("cancel_no_done", done, 0);

    issue(OP_MTHI, 32'h1234, 32'h0, 1'b0, 0, 0, 0, 1'b0);
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo", lo, 32'hC);
    check("mthi_busy", busy, 0);
    issue(OP_MTLO, 32'h5678, 32'h0, 1'b0, 0, 0, 0, 1'b0);
    check("mtlo_lo", lo, 32'h5678);
    check("mtlo_hi", hi, 32'h1234);

    // Reset in the middle of a divide.
    issue(OP_DIVU, 32'd50, 32'd3, 1'b0, 0, 0, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", req_ready, 1);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    run("divu_3_10", OP_DIVU, 32'd3, 32'd10, 32'h3, 32'h0, EL);

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width; even and >=8.
REQ-002 SHALL have parameter MUL_STAGES, default 2, multiply latency in cycles; range 1..4.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  operation request.
REQ-006 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-007 SHALL have port req_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; others ignored.
REQ-008 SHALL have port req_a  input  WIDTH  multiplicand/dividend/MTHI-MTLO source.
REQ-009 SHALL have port req_b  input  WIDTH  multiplier/divisor.
REQ-010 SHALL have port cancel  input  1  abort in-flight multiply/divide.
REQ-011 SHALL have port busy  output  1  multiply/divide in flight; HI/LO not final.
REQ-012 SHALL have port done  output  1  one-cycle pulse, new HI/LO visible this cycle.
REQ-013 SHALL have ports hi, lo  output  WIDTH  architectural HI/LO registers.

Function
REQ-014 SHALL implement states IDLE, MUL, DIV, FIX; req_ready = (state==IDLE); busy = (state!=IDLE).
REQ-015 SHALL accept MULT/MULTU at edge T0 (IDLE, req_valid): enter MUL, write full 2*WIDTH product {hi,lo} at edge T0+MUL_STAGES, return IDLE.
REQ-016 SHALL accept DIV/DIVU at T0: enter DIV, perform WIDTH radix-2 restoring iterations on magnitudes, then FIX for sign correction; write lo=quotient, hi=remainder at edge T0+WIDTH+1, return IDLE.
REQ-017 SHALL truncate signed quotient toward zero; remainder sign SHALL equal dividend sign.
REQ-018 SHALL on divisor zero (both signedness) produce lo = all ones, hi = req_a.
REQ-019 SHALL on signed MIN / -1 produce lo = MIN, hi = 0.
REQ-020 SHALL latch req_a, req_b, op at acceptance; later input changes have no effect.
REQ-021 SHALL execute MTHI/MTLO only in IDLE: hi (resp. lo) <= req_a at acceptance edge; no done pulse; other register unchanged.
REQ-022 SHALL drive done high for exactly the cycle following the HI/LO write edge of a MUL/DIV.
REQ-023 SHALL on cancel in MUL/DIV/FIX return to IDLE at next edge, leave HI/LO unchanged, suppress done; cancel has priority over completion in the same cycle.
REQ-024 SHALL ignore cancel in IDLE; request with cancel in IDLE is accepted normally.
REQ-025 SHALL ignore req_valid while busy; no queueing.

Reset
REQ-026 SHALL on reset, at any time including mid-operation, force state IDLE, hi=0, lo=0, done=0, busy=0, req_ready=1.
REQ-027 SHALL discard in-flight operands and counters on reset; first post-reset request behaves as fresh.

Configuration
REQ-028 SHALL support macro MULDIV_EARLY_OUT_EN.
REQ-029 SHALL with MULDIV_EARLY_OUT_EN defined complete a divide at edge T0+1 when divisor is zero or |dividend| < |divisor|, with results per REQ-017/018 (lo=0, hi=req_a for the magnitude case); done one cycle later.
REQ-030 SHALL without MULDIV_EARLY_OUT_EN complete every divide at T0+WIDTH+1; results identical either way.

Verification (WIDTH=32, MUL_STAGES=2)
REQ-031 SHALL cover MULT a=0xFFFFFFFF b=0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, done at T0+2 cycle.
REQ-032 SHALL cover MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-033 SHALL cover DIV a=0xFFFFFFF9 b=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, busy 33 cycles (macro off).
REQ-034 SHALL cover DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=0x00000005; with macro, written at T0+1.
REQ-035 SHALL cover DIV a=100 b=7 with cancel at T0+10 -> busy low at T0+11, HI/LO unchanged, no done; following MTHI a=0x1234 -> hi=0x00001234.
REQ-036 SHALL cover reset asserted at T0+5 of DIVU -> hi=lo=0, IDLE immediately; DIVU 3/10 after release -> lo=0, hi=3 (T0+1 with macro, T0+33 without).
